// File: rtl/axi_bridge.sv
// Bridges the CPU instruction-fetch and data request ports onto one AXI4 master.
// Keeps at most one AXI transaction in flight. When both ports ask at once, the data port wins.
module axi_bridge (
  input  logic        clock,
  input  logic        reset,

  input  logic        ireq_valid,
  output logic        ireq_ready,
  input  logic [31:0] ireq_addr,
  input  logic [7:0]  ireq_len,

  output logic        iresp_valid,
  output logic [63:0] iresp_data,
  output logic        iresp_last,
  output logic        iresp_err,

  input  logic        dreq_valid,
  output logic        dreq_ready,
  input  logic        dreq_write,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_len,
  input  logic [63:0] dreq_wdata,
  input  logic [7:0]  dreq_wstrb,

  output logic        dresp_valid,
  output logic [63:0] dresp_data,
  output logic        dresp_last,
  output logic        dresp_err,

  output logic        awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic [3:0]  awqos,
  output logic        awuser,
  output logic        awvalid,
  input  logic        awready,

  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,

  output logic        arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic [3:0]  arqos,
  output logic        aruser,
  output logic        arvalid,
  input  logic        arready,

  input  logic        rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} stateT;

  stateT       state_q, state_d;
  logic        ownerD_q, ownerD_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        awDone_q, awDone_d;
  logic        wDone_q, wDone_d;

  // Response IDs carry no information with a single outstanding transaction.
  logic unusedIds;
  assign unusedIds = rid ^ bid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ownerD_q <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ownerD_q <= ownerD_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ownerD_d    = ownerD_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awDone_d    = awDone_q;
    wDone_d     = wDone_q;
    ireq_ready  = 1'b0;
    dreq_ready  = 1'b0;
    iresp_valid = 1'b0;
    iresp_data  = '0;
    iresp_last  = 1'b0;
    iresp_err   = 1'b0;
    dresp_valid = 1'b0;
    dresp_data  = '0;
    dresp_last  = 1'b0;
    dresp_err   = 1'b0;
    arvalid     = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    rready      = 1'b0;
    bready      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dreq_valid) begin
          dreq_ready = 1'b1;
          ownerD_d   = 1'b1;
          addr_d     = dreq_addr;
          len_d      = dreq_write ? 8'd0 : dreq_len;
          size_d     = dreq_size;
          wdata_d    = dreq_wdata;
          wstrb_d    = dreq_wstrb;
          state_d    = dreq_write ? WADDR : RADDR;
        end else if (ireq_valid) begin
          ireq_ready = 1'b1;
          ownerD_d   = 1'b0;
          addr_d     = ireq_addr;
          len_d      = ireq_len;
          size_d     = 3'b011;
          wdata_d    = '0;
          wstrb_d    = '0;
          state_d    = RADDR;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (ownerD_q) begin
            dresp_valid = 1'b1;
            dresp_data  = rdata;
            dresp_last  = rlast;
            dresp_err   = (rresp != 2'b00);
          end else begin
            iresp_valid = 1'b1;
            iresp_data  = rdata;
            iresp_last  = rlast;
            iresp_err   = (rresp != 2'b00);
          end
          if (rlast) state_d = IDLE;
        end
      end
      WADDR: begin
        // Address and data channels retire independently; move on once both have.
        awvalid  = !awDone_q;
        wvalid   = !wDone_q;
        awDone_d = awDone_q | (awvalid & awready);
        wDone_d  = wDone_q | (wvalid & wready);
        if (awDone_d && wDone_d) begin
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          dresp_valid = 1'b1;
          dresp_last  = 1'b1;
          dresp_err   = (bresp != 2'b00);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = ownerD_q ? size_q : 3'b011;
  assign arburst = 2'b01;
  assign arid    = ownerD_q;
  assign arprot  = ownerD_q ? 3'b000 : 3'b100;
  assign arlock  = 1'b0;
  assign arcache = 4'b0000;
  assign arqos   = 4'b0000;
  assign aruser  = 1'b0;

  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awid    = 1'b0;
  assign awprot  = 3'b000;
  assign awlock  = 1'b0;
  assign awcache = 4'b0000;
  assign awqos   = 4'b0000;
  assign awuser  = 1'b0;

  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign wlast = 1'b1;

endmodule

// File: doc/axi_bridge.md
AXI_BRIDGE -- requirements
Module: axi_bridge

Interface
REQ-001 SHALL have `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the instruction-fetch request port:
- `ireq_valid` in 1, `ireq_ready` out 1.
- `ireq_addr` in 32: read address.
- `ireq_len` in 8: AXI beats minus 1.
REQ-004 SHALL have the instruction response port: `iresp_valid` out 1, `iresp_data` out 64, `iresp_last` out 1, `iresp_err` out 1.
REQ-005 SHALL have the data request port:
- `dreq_valid` in 1, `dreq_ready` out 1.
- `dreq_write` in 1: 1 = write, 0 = read.
- `dreq_addr` in 32, `dreq_size` in 3, `dreq_len` in 8 (read only).
- `dreq_wdata` in 64, `dreq_wstrb` in 8.
REQ-006 SHALL have the data response port: `dresp_valid` out 1, `dresp_data` out 64, `dresp_last` out 1, `dresp_err` out 1.
REQ-007 SHALL expose the full AXI4 master port: aw*, w*, b*, ar*, r* channels; 32-bit addresses, 64-bit data, 1-bit id, plus `awuser`/`aruser`/`awqos`/`arqos`. Signal set and widths match the CPU top-level master port, so the two connect one-to-one.

Function
REQ-008 SHALL run one FSM with states IDLE, RADDR, RDATA, WADDR, WRESP, and allow at most one outstanding AXI transaction.
REQ-009 In IDLE, arbitration SHALL be fixed priority: `dreq_valid` wins over `ireq_valid`.
REQ-010 Only the granted port's ready SHALL pulse, for exactly one cycle, and only while in IDLE.
REQ-011 On accept, the bridge SHALL latch addr/len/size/wdata/wstrb and the owner (I or D). The next state is WADDR if the request is a data write, else RADDR.
REQ-012 Read-address fields in RADDR:
- `arvalid`=1; `araddr` = latched addr; `arlen` = latched len; `arburst`=01.
- I owner: `arsize`=011, `arid`=0, `arprot`=100.
- D owner: `arsize` = latched size, `arid`=1, `arprot`=000.
- RADDR -> RDATA on `arready`; `arvalid` holds until then.
REQ-013 Read data in RDATA:
- `rready`=1.
- Each `rvalid` beat drives the owner's resp_valid combinationally, with data=`rdata`, last=`rlast`, err=(`rresp`!=00).
- Consumers cannot stall a response.
- The beat with `rlast` returns the FSM to IDLE.
REQ-014 Write in WADDR:
- `awvalid` and `wvalid` assert together.
- Fields: `awlen`=0, `awsize` = latched size, `awburst`=01, `awid`=0, `wlast`=1, wdata/wstrb = latched values.
REQ-015 Each of `awvalid`/`wvalid` SHALL drop independently on its own handshake, tracked by aw_done/w_done flags. Either order, or both in the same cycle, SHALL be accepted. WADDR -> WRESP once both are done.
REQ-016 In WRESP, `bready`=1. On `bvalid`, the bridge SHALL pulse `dresp_valid` for one cycle with `dresp_last`=1, `dresp_data`=0, and `dresp_err`=(`bresp`!=00), then return to IDLE.
REQ-017 The bridge SHALL ignore `rid`, `bid` and the response content of the non-owner; the non-owner's resp_valid stays 0.
REQ-018 Constant outputs: `awprot`=000, `awlock`=`arlock`=0, `awcache`=`arcache`=0000, `awqos`=`arqos`=0000, `awuser`=`aruser`=0.
REQ-019 Address/size outputs SHALL come only from latched registers. They SHALL NOT change while a valid is high and unacknowledged.
REQ-020 If a request's valid drops while the bridge is busy, it SHALL be dropped silently; requests are sampled only in IDLE.

Reset
REQ-021 `reset` high at a clock edge SHALL force IDLE and clear aw_done/w_done, from any state, including mid-burst or mid-handshake.
REQ-022 In the cycle after reset, the following SHALL all be 0: `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `ireq_ready`, `dreq_ready`, `iresp_valid`, `dresp_valid`. Latched registers SHALL be 0.
REQ-023 An AXI transaction aborted by reset is not resumed; slave-side recovery is the system's responsibility.

Verification
REQ-024 I-burst: ireq addr 0x80000000, len 3; slave returns 4 beats D0..D3 -> one AR with arlen=3, arsize=3, arid=0, arprot=4; 4 iresp_valid beats, iresp_last only on D3; then IDLE.
REQ-025 Priority: ireq and dreq read 0x80001000 asserted the same cycle -> dreq_ready pulses, ireq_ready stays 0; araddr=0x80001000, arid=1. After rlast, ireq is granted on the next IDLE cycle.
REQ-026 Write skew: dreq write addr 0x80002008, strb 0xF0, data 0x1122334455667788; slave gives wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds; bvalid with bresp=00 -> one dresp_valid with dresp_err=0.
REQ-027 Error: I read with rresp=10 on its single beat -> iresp_valid=1, iresp_err=1, iresp_last=1.
REQ-028 Reset mid-burst: reset asserted after beat 2 of a 4-beat read -> next cycle all valids and rready are 0, state IDLE. A following ireq is accepted normally.
